recursive_multiplication: RTL and testbench

RECURSIVE_MULTIPLICATION -- requirements
Module: recursive_multiplication

---
 rtl/recursive_multiplication.sv | 126 ++++++++++++
 tb/tb_recursive_multiplication.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/recursive_multiplication.sv
// ---------------------------------------------------------------------------
// recursive_multiplication
//
// Sequential shift-and-add multiply-accumulate:
//   product = multiplicand * multiplier + addend
// computed over eight clock cycles, one multiplier bit per cycle, LSB first.
// Operand widths match a 17/9 divider's outputs, so feeding it a quotient,
// divisor and remainder gives back the dividend.
//
// Ports
//   clk           in   1   rising-edge clock
//   resetn        in   1   asynchronous active-low reset
//   multiplier    in   8   unsigned multiplier (quotient)
//   multiplicand  in   9   unsigned multiplicand (divisor)
//   addend        in   9   unsigned addend (remainder)
//   data_en       in   1   load strobe
//   product       out  17  registered result, held until the next completion
//   busy          out  1   operation in progress
//   done          out  1   one-cycle pulse when product is written
//   state_dbg     out  2   current FSM state (0 IDLE, 1 CALC, 2 DONE)
//
// Handshake: data_en is a single-cycle load request. It is accepted only at
// a rising edge where the FSM is in IDLE (busy=0 and done=0); a request seen
// at any other edge, including the DONE cycle, is dropped, not queued. The
// result is signalled by done (valid for exactly one cycle, no ready/back
// pressure); product keeps that value afterwards.
//
// Timing for a load accepted at edge N:
//   edges N+1..N+8  one iteration each (counter 0..7)
//   edge  N+9       counter has reached 8: product written, done=1
//   edge  N+10      back to IDLE, busy=0, done=0
// ---------------------------------------------------------------------------
module recursive_multiplication (
  input  logic        clk,
  input  logic        resetn,
  input  logic [7:0]  multiplier,
  input  logic [8:0]  multiplicand,
  input  logic [8:0]  addend,
  input  logic        data_en,
  output logic [16:0] product,
  output logic        busy,
  output logic        done,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  logic [3:0]  iter_cnt;
  logic [7:0]  mplr_q;
  logic [8:0]  mcand_q;
  logic [16:0] acc;

  // Multiplicand aligned to the current bit position. Zero-extended to the
  // full accumulator width before shifting so the top bits are never lost.
  logic [16:0] partial;
  logic        take_bit;

  always_comb begin
    partial  = {8'd0, mcand_q} << iter_cnt[2:0];
    take_bit = mplr_q[iter_cnt[2:0]];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      iter_cnt <= 4'd0;
      mplr_q   <= 8'd0;
      mcand_q  <= 9'd0;
      acc      <= 17'd0;
      product  <= 17'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (data_en) begin
            // Operands are latched here so later input activity cannot
            // disturb the running operation.
            mplr_q   <= multiplier;
            mcand_q  <= multiplicand;
            acc      <= {8'd0, addend};
            iter_cnt <= 4'd0;
            busy     <= 1'b1;
            state    <= CALC;
          end
        end

        CALC: begin
          // Counter value 8 marks "all bits consumed"; every operand, zero
          // or not, spends the same eight iterations here.
          if (iter_cnt == 4'd8) begin
            product <= acc;
            done    <= 1'b1;
            state   <= DONE;
          end else begin
            if (take_bit) begin
              acc <= acc + partial;
            end
            iter_cnt <= iter_cnt + 4'd1;
          end
        end

        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_recursive_multiplication.sv
// ---------------------------------------------------------------------------
// tb_recursive_multiplication
//
// Driver tasks issue loads and push the model's expected product and the
// cycle at which it must appear; an independent monitor pops and compares
// whenever done is seen. The reference is plain integer arithmetic.
// ---------------------------------------------------------------------------
module tb_recursive_multiplication;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        resetn;
  logic [7:0]  multiplier;
  logic [8:0]  multiplicand;
  logic [8:0]  addend;
  logic        data_en;
  logic [16:0] product;
  logic        busy;
  logic        done;
  logic [1:0]  state_dbg;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  recursive_multiplication dut (
    .clk          (clk),
    .resetn       (resetn),
    .multiplier   (multiplier),
    .multiplicand (multiplicand),
    .addend       (addend),
    .data_en      (data_en),
    .product      (product),
    .busy         (busy),
    .done         (done),
    .state_dbg    (state_dbg)
  );

  // ---------------- scoreboard state ----------------
  int          checks = 0;
  int          errors = 0;
  logic [16:0] exp_q[$];
  int          exp_cyc_q[$];
  logic [16:0] last_exp = 17'd0;
  logic        prev_done = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model: the arithmetic definition of the result.
  function automatic int ref_mac(input int m, input int c, input int a);
    return c * m + a;
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (done === 1'b1) begin
      check("done_single_cycle", {31'd0, prev_done}, 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_done", {31'd0, done}, 32'd0);
      end else begin
        logic [16:0] e;
        int          ec;
        e  = exp_q.pop_front();
        ec = exp_cyc_q.pop_front();
        check("product", {15'd0, product}, {15'd0, e});
        check("latency", cyc, ec);
      end
    end
    prev_done <= done;
  end

  // ---------------- driver ----------------
  // Issues one load, then walks the ten cycles up to the next IDLE edge.
  // Operand inputs are scrambled every cycle after the load. glitch_k pulses
  // data_en after edge N+glitch_k (must be ignored); abort_k asserts reset
  // after edge N+abort_k. expect_val < 0 means use the model.
  task automatic run_op(input logic [7:0] m, input logic [8:0] c, input logic [8:0] a,
                        input int glitch_k, input int abort_k, input int expect_val);
    logic [16:0] e;
    multiplier   = m;
    multiplicand = c;
    addend       = a;
    data_en      = 1'b1;
    @(negedge clk);
    data_en = 1'b0;
    e = (expect_val < 0) ? 17'(ref_mac(int'(m), int'(c), int'(a))) : 17'(expect_val);
    if (abort_k == 0) begin
      exp_q.push_back(e);
      exp_cyc_q.push_back(cyc + 9);
    end
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      multiplier   = 8'($urandom);
      multiplicand = 9'($urandom);
      addend       = 9'($urandom);
      data_en      = (k == glitch_k);
      if (k == abort_k) begin
        resetn = 1'b0;
        #1;
        check("abort_product", {15'd0, product}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        data_en = 1'b1;
        repeat (2) @(negedge clk);
        check("abort_hold_busy", {31'd0, busy}, 32'd0);
        resetn   = 1'b1;
        data_en  = 1'b0;
        last_exp = 17'd0;
        repeat (12) @(negedge clk);
        check("abort_idle_busy", {31'd0, busy}, 32'd0);
        check("abort_idle_product", {15'd0, product}, 32'd0);
        return;
      end
      check("busy", {31'd0, busy}, (k <= 9) ? 32'd1 : 32'd0);
      if (k <= 8) check("product_hold", {15'd0, product}, {15'd0, last_exp});
    end
    last_exp = e;
    check("product_after", {15'd0, product}, {15'd0, e});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    resetn       = 1'b0;
    data_en      = 1'b1;
    multiplier   = 8'd17;
    multiplicand = 9'd33;
    addend       = 9'd9;
    repeat (3) @(negedge clk);
    check("reset_product", {15'd0, product}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    resetn  = 1'b1;
    data_en = 1'b0;
    repeat (2) @(negedge clk);
    check("post_reset_busy", {31'd0, busy}, 32'd0);

    run_op(8'd13,  9'd7,   9'd5,   0, 0, -1);   // 96
    run_op(8'd255, 9'd511, 9'd511, 0, 0, -1);   // 130816
    run_op(8'd0,   9'd300, 9'd0,   0, 0, -1);   // 0
    run_op(8'd200, 9'd0,   9'd42,  0, 0, -1);   // 42
    run_op(8'd3,   9'd4,   9'd1,   3, 0, -1);   // 13, mid-op load ignored
    run_op(8'd9,   9'd9,   9'd0,   0, 0, -1);   // 81
    run_op(8'd13,  9'd7,   9'd5,   9, 0, -1);   // load in DONE cycle ignored
    run_op(8'd100, 9'd100, 9'd0,   0, 5, -1);   // aborted by reset
    run_op(8'd2,   9'd3,   9'd1,   0, 0, -1);   // 7

    // Divider round trip: quotient, divisor, remainder rebuild the dividend.
    for (int i = 0; i < 1000; i++) begin
      int d, dividend, q, r;
      d        = int'($urandom_range(1, 511));
      dividend = int'($urandom_range(0, 256 * d - 1));
      q        = dividend / d;
      r        = dividend % d;
      run_op(8'(q), 9'(d), 9'(r), 0, 0, dividend);
    end

    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
